ram_wb_arbiter: RTL and testbench

RAM_WB_ARBITER -- requirements
Module: ram_wb_arbiter

---
 rtl/ram_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of a single RAM port, with a forced idle cycle between grants.
// Define RAM_ARB_RR_EN for round-robin on contested requests; otherwise m0 has fixed priority.
module ram_wb_arbiter #(
    parameter int AWIDTH = 13
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic [AWIDTH-1:0] m0_adr_i,
    input  logic [31:0]       m0_dat_i,
    output logic [31:0]       m0_dat_o,
    input  logic              m0_we_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    input  logic [3:0]        m0_sel_i,
    output logic              m0_ack_o,

    input  logic [AWIDTH-1:0] m1_adr_i,
    input  logic [31:0]       m1_dat_i,
    output logic [31:0]       m1_dat_o,
    input  logic              m1_we_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    input  logic [3:0]        m1_sel_i,
    output logic              m1_ack_o,

    output logic [AWIDTH-1:0] s_adr_o,
    output logic [31:0]       s_dat_o,
    output logic              s_we_o,
    output logic              s_stb_o,
    output logic [3:0]        s_sel_o,
    input  logic [31:0]       s_dat_i,
    input  logic              s_ack_i,

    output logic [1:0]        gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e     state_q;
    logic [1:0] gnt_q;
    logic       pick1;

`ifdef RAM_ARB_RR_EN
    logic last_q;  // 1 = m1 was granted most recently
    assign pick1 = ~last_q;
`else
    assign pick1 = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
`ifdef RAM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || !pick1)) begin
                        state_q <= GNT0;
                        gnt_q   <= 2'b01;
`ifdef RAM_ARB_RR_EN
                        last_q  <= 1'b0;
`endif
                    end else if (m1_cyc_i) begin
                        state_q <= GNT1;
                        gnt_q   <= 2'b10;
`ifdef RAM_ARB_RR_EN
                        last_q  <= 1'b1;
`endif
                    end
                end
                // Release always passes through IDLE so a stale ack cannot leak to the next owner.
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    logic sel0, sel1, live;

    assign sel0 = (state_q == GNT0);
    assign sel1 = (state_q == GNT1);
    // Strobe and acks are also masked during reset so nothing completes in the reset cycle.
    assign live = ~wb_rst_i;

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = 4'b0000;
        s_stb_o = 1'b0;
        if (sel0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i & m0_cyc_i & live;
        end else if (sel1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i & m1_cyc_i & live;
        end
    end

    assign m0_ack_o = s_ack_i & sel0 & live;
    assign m1_ack_o = s_ack_i & sel1 & live;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Bench for ram_wb_arbiter: directed scenarios plus a randomized run against an ownership model.
// A small single-cycle-ack RAM model sits on the slave port.
module tb_ram_wb_arbiter;
    localparam int AW = 13;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, rst;
    logic [AW-1:0] adr [2];
    logic [31:0]   wdat [2];
    logic          we [2], stb [2], cyc [2];
    logic [3:0]    sel [2];
    logic [31:0]   rdat0, rdat1;
    logic          ack0, ack1;
    logic          mack [2];
    logic [AW-1:0] s_adr;
    logic [31:0]   s_dato, s_dati;
    logic          s_we, s_stb, s_ack;
    logic [3:0]    s_sel;
    logic [1:0]    gnt;

    logic [31:0]   mem [0:2047];
    logic          ram_ack, inj_ack;

    int checks = 0;
    int errors = 0;

    ram_wb_arbiter #(.AWIDTH(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat0), .m0_we_i(we[0]),
        .m0_stb_i(stb[0]), .m0_cyc_i(cyc[0]), .m0_sel_i(sel[0]), .m0_ack_o(ack0),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat1), .m1_we_i(we[1]),
        .m1_stb_i(stb[1]), .m1_cyc_i(cyc[1]), .m1_sel_i(sel[1]), .m1_ack_o(ack1),
        .s_adr_o(s_adr), .s_dat_o(s_dato), .s_we_o(s_we), .s_stb_o(s_stb), .s_sel_o(s_sel),
        .s_dat_i(s_dati), .s_ack_i(s_ack), .gnt_o(gnt)
    );

    assign mack[0] = ack0;
    assign mack[1] = ack1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: registered ack (ack <= stb & ~ack), byte-lane writes, asynchronous read.
    assign s_dati = mem[s_adr[AW-1:2]];
    assign s_ack  = ram_ack | inj_ack;
    always @(posedge clk) begin
        if (rst) ram_ack <= 1'b0;
        else begin
            ram_ack <= s_stb & ~ram_ack;
            if (s_stb && !ram_ack && s_we)
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[AW-1:2]][b*8 +: 8] <= s_dato[b*8 +: 8];
        end
    end

    task automatic idle_masters();
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 0; stb[m] = 0; we[m] = 0; adr[m] = '0; wdat[m] = '0; sel[m] = '0;
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        idle_masters();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic access(input int m, input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd, output bit ok);
        @(posedge clk); #1;
        cyc[m] = 1; stb[m] = 1; adr[m] = a; we[m] = w; wdat[m] = d; sel[m] = s;
        ok = 0; rd = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (mack[m]) begin ok = 1; rd = (m == 1) ? rdat1 : rdat0; end
        end
        @(posedge clk); #1;
        cyc[m] = 0; stb[m] = 0; we[m] = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1; rst = 1; idle_masters();
        @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", s_stb); end
        if (s_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", s_we); end
        if ({ack1, ack0} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", {ack1, ack0}); end
        if (s_adr !== '0 || s_sel !== 4'b0) begin errors++; $display("FAIL reset_adr_sel: got %h/%b expected 0/0", s_adr, s_sel); end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_read_m0();
        bit got = 0, m1_seen = 0;
        mem[13'h0010 >> 2] = 32'hDEADBEEF;
        reset_dut();
        cyc[0] = 1; stb[0] = 1; adr[0] = 13'h0010; sel[0] = 4'hF;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL read_latency: got %b expected 00", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL read_gnt: got %b expected 01", gnt); end
        for (int i = 0; i < 10 && !got; i++) begin
            if (ack1) m1_seen = 1;
            if (ack0) begin
                got = 1; checks++;
                if (rdat0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", rdat0); end
            end else @(negedge clk);
        end
        checks += 2;
        if (!got) begin errors++; $display("FAIL read_ack: got none expected m0 ack"); end
        if (m1_seen) begin errors++; $display("FAIL read_m1_ack: got 1 expected 0"); end
        @(posedge clk); #1; idle_masters();
    endtask

    task automatic test_contest();
        bit got = 0;
        reset_dut();
        cyc[0] = 1; stb[0] = 1; adr[0] = 13'h0040; sel[0] = 4'hF;
        cyc[1] = 1; stb[1] = 1; adr[1] = 13'h0030; sel[1] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL contest_first: got %b expected 01", gnt); end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ack0) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL contest_m0_ack: got none expected ack"); end
        @(posedge clk); #1; cyc[0] = 0; stb[0] = 0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL contest_idle: got %b expected 00", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin errors++; $display("FAIL contest_second: got %b expected 10", gnt); end
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ack1) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL contest_m1_ack: got none expected ack"); end
        @(posedge clk); #1; idle_masters();
    endtask

    task automatic test_alternate();
        logic [1:0] runs [$];
        logic [1:0] exp_seq [5];
        logic       a [2];
        if (RR) exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        else    exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        reset_dut();
        for (int m = 0; m < 2; m++) begin
            cyc[m] = 1; stb[m] = 1; adr[m] = AW'(m * 8); sel[m] = 4'hF;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!(runs.size() == 0 && gnt == 2'b00) && (runs.size() == 0 || runs[$] != gnt))
                runs.push_back(gnt);
            a[0] = ack0; a[1] = ack1;
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                cyc[m] = !(cyc[m] && a[m]);
                stb[m] = cyc[m];
            end
        end
        checks++;
        if (runs.size() < 5) begin errors++; $display("FAIL alt_len: got %0d expected >=5", runs.size()); end
        else for (int i = 0; i < 5; i++) begin
            checks++;
            if (runs[i] !== exp_seq[i]) begin
                errors++; $display("FAIL alt_seq[%0d]: got %b expected %b", i, runs[i], exp_seq[i]);
            end
        end
        @(posedge clk); #1; idle_masters();
        @(posedge clk); @(posedge clk);
    endtask

    task automatic test_byte_write();
        logic [31:0] rd, old, expv;
        bit ok;
        mem[13'h0020 >> 2] = 32'hAABBCCDD;
        old  = 32'hAABBCCDD;
        expv = (old & 32'hFFFF0000) | (32'h12345678 & 32'h0000FFFF);
        access(1, 13'h0020, 1'b1, 32'h12345678, 4'b0011, rd, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bw_write_ack: got none expected ack"); end
        access(1, 13'h0020, 1'b0, 32'h0, 4'hF, rd, ok);
        checks++;
        if (!ok || rd !== expv) begin errors++; $display("FAIL bw_readback: got %h expected %h", rd, expv); end
    endtask

    task automatic test_abort();
        reset_dut();
        cyc[0] = 1; stb[0] = 1; adr[0] = 13'h0100; sel[0] = 4'hF;
        @(posedge clk); #1;
        cyc[0] = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin errors++; $display("FAIL abort_gnt: got %b expected 01", gnt); end
        @(posedge clk); #1;
        inj_ack = 1;
        @(negedge clk);
        checks += 2;
        if (gnt !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b expected 00", gnt); end
        if ({ack1, ack0} !== 2'b00) begin errors++; $display("FAIL abort_late_ack: got %b expected 00", {ack1, ack0}); end
        @(posedge clk); #1;
        inj_ack = 0; idle_masters();
    endtask

    task automatic test_reset_mid();
        reset_dut();
        cyc[1] = 1; stb[1] = 1; adr[1] = 13'h0200; sel[1] = 4'hF;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        checks += 2;
        if (gnt !== 2'b10) begin errors++; $display("FAIL rstmid_gnt: got %b expected 10", gnt); end
        if (ack1 !== 1'b0) begin errors++; $display("FAIL rstmid_ack_a: got %b expected 0", ack1); end
        @(negedge clk);
        checks += 3;
        if (gnt !== 2'b00) begin errors++; $display("FAIL rstmid_drop: got %b expected 00", gnt); end
        if (s_stb !== 1'b0) begin errors++; $display("FAIL rstmid_stb: got %b expected 0", s_stb); end
        if (ack1 !== 1'b0) begin errors++; $display("FAIL rstmid_ack_b: got %b expected 0", ack1); end
        @(posedge clk); #1;
        idle_masters(); rst = 0;
    endtask

    task automatic test_random();
        int         owner = -1;
        bit         last = 1;
        logic       seen [2];
        logic [1:0] eg;
        logic       es;
        seen[0] = 0; seen[1] = 0;
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            // Ownership rules: one owner at a time, always released through an idle cycle.
            if (rst) begin owner = -1; last = 1; end
            else if (owner < 0) begin
                if (cyc[0] && cyc[1]) owner = (RR && !last) ? 1 : 0;
                else if (cyc[0]) owner = 0;
                else if (cyc[1]) owner = 1;
                if (owner >= 0) last = (owner == 1);
            end else if (!cyc[owner]) owner = -1;
            #1;
            rst = ($urandom_range(0, 63) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!cyc[m] || seen[m]) begin
                    if ($urandom_range(0, 2) == 0 || (cyc[m] && $urandom_range(0, 1) == 0)) begin
                        cyc[m] = 1; stb[m] = 1; adr[m] = AW'($urandom());
                        we[m] = 1'($urandom()); wdat[m] = $urandom(); sel[m] = 4'($urandom());
                    end else begin
                        cyc[m] = 0; stb[m] = 0;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    cyc[m] = 0; stb[m] = 0;
                end
            end
            @(negedge clk);
            eg = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
            es = !rst && owner >= 0 && stb[owner] && cyc[owner];
            checks += 5;
            if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, gnt, eg); end
            if (s_stb !== es) begin errors++; $display("FAIL rnd_stb c%0d: got %b expected %b", c, s_stb, es); end
            if (ack0 !== (s_ack && owner == 0 && !rst)) begin errors++; $display("FAIL rnd_ack0 c%0d: got %b", c, ack0); end
            if (ack1 !== (s_ack && owner == 1 && !rst)) begin errors++; $display("FAIL rnd_ack1 c%0d: got %b", c, ack1); end
            if (s_adr !== ((owner < 0) ? '0 : adr[owner])) begin errors++; $display("FAIL rnd_adr c%0d: got %h", c, s_adr); end
            seen[0] = ack0; seen[1] = ack1;
        end
        @(posedge clk); #1; idle_masters(); rst = 0;
    endtask

    initial begin
        rst = 1; inj_ack = 0;
        idle_masters();
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
        test_reset();
        test_read_m0();
        test_contest();
        test_alternate();
        test_byte_write();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
